// File: rtl/oled_pkg.sv
// Shared types and constants for the SSD1306 SPI arbiter: FSM state encoding,
// channel indices and D/C levels.
package oled_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LOAD,
        ST_BLANK,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } oled_arb_state_t;

    localparam logic OLED_CH_CMD  = 1'b0;
    localparam logic OLED_CH_DATA = 1'b1;

    localparam logic OLED_DC_CMD  = 1'b0;
    localparam logic OLED_DC_DATA = 1'b1;

endpackage

// File: rtl/oled_arb_picker.sv
// Grant decision for the two SPI producers; the result is always one-hot or zero.
// Build option OLED_ARB_ROUND_ROBIN_EN adds an alternating pointer, otherwise channel 0 wins.
module oled_arb_picker
    import oled_pkg::*;
(
    input  logic       clk_in,
    input  logic       resetn,
    input  logic [1:0] req_valid,
    input  logic       burst_done,
    output logic [1:0] pick
);

`ifdef OLED_ARB_ROUND_ROBIN_EN
    logic rr_ptr;

    // The pointer flips after every finished or forced burst, whoever owned it.
    always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn) begin
            rr_ptr <= OLED_CH_CMD;
        end else if (burst_done) begin
            rr_ptr <= ~rr_ptr;
        end
    end

    always_comb begin
        pick = 2'b00;
        if (req_valid[rr_ptr]) begin
            pick[rr_ptr] = 1'b1;
        end else if (req_valid[~rr_ptr]) begin
            pick[~rr_ptr] = 1'b1;
        end
    end
`else
    logic unused_picker;
    assign unused_picker = ^{clk_in, resetn, burst_done};

    always_comb begin
        pick = 2'b00;
        if (req_valid[OLED_CH_CMD]) begin
            pick[OLED_CH_CMD] = 1'b1;
        end else if (req_valid[OLED_CH_DATA]) begin
            pick[OLED_CH_DATA] = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/oled_spi_arbiter.sv
// Shares one SSD1306 SPI shift register between the command and display-data producers,
// owning chip select and D/C for the whole burst. Build option: OLED_ARB_ROUND_ROBIN_EN.
module oled_spi_arbiter
    import oled_pkg::*;
#(
    parameter int unsigned CS_GAP       = 2,
    parameter int unsigned HOLD_TIMEOUT = 255
) (
    input  logic       clk_in,
    input  logic       resetn,
    input  logic [1:0] req_valid,
    input  logic [7:0] req_data0,
    input  logic [7:0] req_data1,
    input  logic [1:0] req_dc,
    input  logic [1:0] req_last,
    output logic [1:0] req_ready,
    output logic       sr_start,
    output logic [7:0] sr_data,
    input  logic       sr_ready,
    output logic       oled_csn,
    output logic       oled_dc,
    output logic [1:0] grant,
    output logic       timeout_err
);

    localparam logic [7:0] GAP_LOAD   = 8'(CS_GAP - 1);
    localparam logic [7:0] HOLD_LIMIT = 8'(HOLD_TIMEOUT - 1);
    localparam bit         HOLD_EN    = (HOLD_TIMEOUT != 0);

    oled_arb_state_t state;
    logic            owner_q;
    logic            last_q;
    logic [7:0]      byte_q;
    logic [7:0]      gap_cnt;
    logic [7:0]      hold_cnt;

    logic [1:0]      pick;
    logic            pick_ch;
    logic [7:0]      idle_byte;
    logic [7:0]      hold_byte;
    logic            burst_done;

    assign pick_ch    = pick[OLED_CH_DATA];
    assign idle_byte  = (pick_ch == OLED_CH_DATA) ? req_data1 : req_data0;
    assign hold_byte  = (owner_q == OLED_CH_DATA) ? req_data1 : req_data0;
    assign burst_done = ((state == ST_SHIFT) && sr_ready && last_q) ||
                        ((state == ST_HOLD) && timeout_err);

    oled_arb_picker u_picker (
        .clk_in     (clk_in),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .burst_done (burst_done),
        .pick       (pick)
    );

    always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            owner_q     <= OLED_CH_CMD;
            last_q      <= 1'b0;
            byte_q      <= 8'h00;
            gap_cnt     <= 8'h00;
            hold_cnt    <= 8'h00;
            req_ready   <= 2'b00;
            sr_start    <= 1'b0;
            sr_data     <= 8'h00;
            oled_csn    <= 1'b1;
            oled_dc     <= OLED_DC_CMD;
            grant       <= 2'b00;
            timeout_err <= 1'b0;
        end else begin
            sr_start    <= 1'b0;
            req_ready   <= 2'b00;
            timeout_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        owner_q  <= pick_ch;
                        byte_q   <= idle_byte;
                        last_q   <= req_last[pick_ch];
                        oled_dc  <= req_dc[pick_ch];
                        grant    <= pick;
                        oled_csn <= 1'b0;
                        state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    sr_start           <= 1'b1;
                    sr_data            <= byte_q;
                    req_ready[owner_q] <= 1'b1;
                    hold_cnt           <= 8'h00;
                    state              <= ST_LOAD;
                end
                ST_LOAD: begin
                    state <= ST_BLANK;
                end
                // The shift register only drops sr_ready a cycle after the load pulse.
                ST_BLANK: begin
                    state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (sr_ready) begin
                        if (last_q) begin
                            oled_csn <= 1'b1;
                            grant    <= 2'b00;
                            gap_cnt  <= GAP_LOAD;
                            state    <= ST_GAP;
                        end else begin
                            state <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (timeout_err) begin
                        oled_csn <= 1'b1;
                        grant    <= 2'b00;
                        gap_cnt  <= GAP_LOAD;
                        state    <= ST_GAP;
                    end else if (req_valid[owner_q]) begin
                        last_q             <= req_last[owner_q];
                        oled_dc            <= req_dc[owner_q];
                        sr_data            <= hold_byte;
                        sr_start           <= 1'b1;
                        req_ready[owner_q] <= 1'b1;
                        hold_cnt           <= 8'h00;
                        state              <= ST_LOAD;
                    end else begin
                        // Pulse on the last idle cycle; the release happens one cycle later.
                        if (HOLD_EN && (hold_cnt == HOLD_LIMIT)) begin
                            timeout_err <= 1'b1;
                        end
                        if (hold_cnt != 8'hFF) begin
                            hold_cnt <= hold_cnt + 8'h01;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == 8'h00) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 8'h01;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
